sfifo_fwft: RTL and testbench
=============================

Name: sfifo_fwft

Overview:
Parametrised synchronous single-clock FIFO. Successor to the basic synchronous FIFO, adding:
- a selectable first-word-fall-through (FWFT) read mode;
- true full at DEPTH words;
- a count of DEPTH+1 values (0..DEPTH);
- programmable almost-full and almost-empty flags;
- overflow and underflow error pulses.

It serves as the general-purpose rate/burst buffer between streaming datapath stages in the switch pipeline.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH words
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when data_count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when data_count <= AE_THRESH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT: acknowledge/pop of the word on dout)
dout  output  DATA_WIDTH  read data
empty  output  1  no readable word
full  output  1  data_count == DEPTH
almost_empty  output  1  data_count <= AE_THRESH
almost_full  output  1  data_count >= AF_THRESH
data_count  output  ADDR_WIDTH+1  words held, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync deassert use):
  - pointers, data_count, dout, overflow, underflow = 0
  - empty = 1, full = 0
  - almost_empty = 1; almost_full = (AF_THRESH == 0)
- Write acceptance: write accepted iff wr_en && !full at the edge.
  - Rejected write: data dropped, no state change, overflow = 1 for the following cycle.
- Read acceptance: read accepted iff rd_en && !empty.
  - Rejected read: dout holds, underflow = 1 for the following cycle.
- Full with wr_en && rd_en: read accepted, write rejected (overflow pulses), count -1.
- Empty with wr_en && rd_en: write accepted, read rejected (underflow pulses), count +1.
- Otherwise a simultaneous accepted read and write leaves data_count unchanged.
- data_count: registered.
  - +1 on write-only, -1 on read-only; never exceeds DEPTH, never wraps below 0.
  - full, empty, almost_* are decoded combinationally from data_count, with empty = (data_count == 0).
- Pointers: ADDR_WIDTH bits, wrap naturally from DEPTH-1 to 0.
- FWFT = 0:
  - dout loads the RAM word at rd_ptr on the edge where the read is accepted, visible after that edge (1-cycle latency).
  - dout holds between reads.
  - empty falls after the edge accepting the first write.
- FWFT = 1:
  - An output register holds the head word; dout always shows the head when !empty.
  - data_count includes the word in the output register.
  - Write into a completely empty FIFO bypasses the RAM into the output register: empty falls and dout is valid after that same edge.
  - On an accepted read, the output register reloads from RAM prefetch, keeping back-to-back reads at 1 word/cycle.
  - If the FIFO drains, dout holds its last value and empty = 1.
  - Ordering is strictly preserved in all bypass/prefetch cases.
- Reset mid-operation: all contents discarded immediately. The first write after reset is the first word read.

Decomposition:
- Shared package/header sfifo_defs holds:
  - FIFO mode constants FIFO_STD = 0, FIFO_FWFT = 1;
  - the DEPTH/count-width derivation macros, shared with the existing FIFO family.
- One sub-module, sfifo_ram_sdp: simple dual-port RAM with synchronous write port (wr_addr, wr_data, wr_en) and synchronous read port (rd_addr, rd_en, rd_data).
  - No reset on the array.
- Read/write control, count, flags and FWFT prefetch logic live in the top.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4 (DEPTH 16), AF=14, AE=2.
1. Reset, then write 0x00..0x0F on consecutive cycles (FWFT=0):
   - full = 1 after the 16th edge; data_count = 16;
   - almost_full rises at count 14;
   - a 17th write gives overflow = 1 for one cycle and count stays 16.
2. From full, read 16 times (FWFT=0):
   - dout sequence 0x00..0x0F, each one cycle after rd_en;
   - empty = 1 after the last read; almost_empty rises at count 2;
   - an extra rd_en pulses underflow and dout holds 0x0F.
3. Simultaneous wr_en and rd_en at count 5 for 20 cycles with incrementing data:
   - count stays 5; data is in order across pointer wrap (ptr 15 to 0).
4. FWFT=1, empty, write 0xA5:
   - after that edge, empty = 0 and dout = 0xA5 with no rd_en;
   - write 0x5A, then rd_en for two cycles: dout = 0xA5, then 0x5A, then empty = 1.
5. Full FIFO with wr_en && rd_en: read accepted, overflow pulses, count = 15. Empty FIFO with both: underflow pulses, count = 1.
6. Assert rst mid-burst at count 9: all outputs return immediately to reset values. The next write/read returns that new word.

Source files
------------

// File: rtl/sfifo_defs.sv
// Shared definitions for the synchronous FIFO family.
// Mode constants and depth/count-width derivations.
package sfifo_defs;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/sfifo_fwft_if.sv
// Streaming FIFO access bundle: write side, read side and status.
// Master drives requests; slave is the FIFO.
interface sfifo_fwft_if
    import sfifo_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);

    logic                               wr_en;
    logic [DATA_WIDTH-1:0]              din;
    logic                               rd_en;
    logic [DATA_WIDTH-1:0]              dout;
    logic                               empty;
    logic                               full;
    logic                               almost_empty;
    logic                               almost_full;
    logic [cnt_width(ADDR_WIDTH)-1:0]   data_count;
    logic                               overflow;
    logic                               underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, empty, full,
        input  almost_empty, almost_full,
        input  data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, empty, full,
        output almost_empty, almost_full,
        output data_count, overflow, underflow
    );

endinterface

// File: rtl/sfifo_ram_sdp.sv
// Simple dual-port RAM: synchronous write, registered read.
// Array and read register are not reset.
module sfifo_ram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sfifo_fwft.sv
// Synchronous FIFO with selectable standard or first-word-fall-through
// read mode, occupancy count, threshold flags and error pulses.
module sfifo_fwft
    import sfifo_defs::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = FIFO_STD,
    parameter int AF_THRESH  = depth_of(ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    sfifo_fwft_if.slave  bus
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  full_w, empty_w, cnt_one;
    logic                  wr_ok, rd_ok;
    logic                  byp, ram_we, ram_re;
    logic                  sel_byp;
    logic [DATA_WIDTH-1:0] byp_q, ram_q;
    logic                  ovf_q, unf_q;

    assign full_w  = (cnt == DEPTH_C);
    assign empty_w = (cnt == '0);
    assign cnt_one = (cnt == ONE_C);
    assign wr_ok   = bus.wr_en && !full_w;
    assign rd_ok   = bus.rd_en && !empty_w;

    // In FWFT the head word lives outside the RAM: a write that becomes
    // the head (empty, or replacing the last word) skips the RAM.
    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign byp    = wr_ok && (empty_w || (rd_ok && cnt_one));
            assign ram_re = rd_ok && !cnt_one;
        end else begin : g_std
            assign byp    = 1'b0;
            assign ram_re = rd_ok;
        end
    endgenerate

    assign ram_we = wr_ok && !byp;

    sfifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.din),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            byp_q   <= '0;
            sel_byp <= 1'b1;
        end else begin
            if (ram_we)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_re)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf_q <= bus.wr_en && full_w;
            unf_q <= bus.rd_en && empty_w;
            // Output source follows whichever path last produced the head
            if (byp) begin
                byp_q   <= bus.din;
                sel_byp <= 1'b1;
            end else if (ram_re) begin
                sel_byp <= 1'b0;
            end
        end
    end

    assign bus.dout         = sel_byp ? byp_q : ram_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.data_count   = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sfifo_fwft.sv
// Bench for sfifo_fwft: standard and FWFT instances share one stimulus
// stream and are compared every cycle against a queue model.
module tb_sfifo_fwft;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;

    int checks   = 0;
    int failures = 0;

    sfifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_std ();
    sfifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_ff  ();

    assign if_std.wr_en = wr_en;
    assign if_std.din   = din;
    assign if_std.rd_en = rd_en;
    assign if_ff.wr_en  = wr_en;
    assign if_ff.din    = din;
    assign if_ff.rd_en  = rd_en;

    sfifo_fwft #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .FWFT (0),
        .AF_THRESH (14), .AE_THRESH (2)
    ) u_std (.clk(clk), .rst(rst), .bus(if_std));

    sfifo_fwft #(
        .DATA_WIDTH (8), .ADDR_WIDTH (4), .FWFT (1),
        .AF_THRESH (14), .AE_THRESH (2)
    ) u_ff (.clk(clk), .rst(rst), .bus(if_ff));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: contents as a queue, plus the last word popped.
    logic [7:0] q [$];
    logic [7:0] last;
    logic       m_ovf, m_unf;
    bit         m_full, m_empty;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            last  = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_full  = (q.size() == 16);
            m_empty = (q.size() == 0);
            m_ovf   = wr_en && m_full;
            m_unf   = rd_en && m_empty;
            if (rd_en && !m_empty)
                last = q.pop_front();
            if (wr_en && !m_full)
                q.push_back(din);
        end
    end

    task automatic cmp(input string tag,
                       input logic [7:0] d,
                       input logic [7:0] exp_d,
                       input logic e, input logic f,
                       input logic ae, input logic af,
                       input logic [4:0] c,
                       input logic o, input logic u);
        int n;
        n = q.size();
        chk({tag, "_count"}, 32'(c), 32'(n));
        chk({tag, "_empty"}, 32'(e), 32'(n == 0));
        chk({tag, "_full"}, 32'(f), 32'(n == 16));
        chk({tag, "_ae"}, 32'(ae), 32'(n <= 2));
        chk({tag, "_af"}, 32'(af), 32'(n >= 14));
        chk({tag, "_ovf"}, 32'(o), 32'(m_ovf));
        chk({tag, "_unf"}, 32'(u), 32'(m_unf));
        chk({tag, "_dout"}, 32'(d), 32'(exp_d));
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            cmp("std", if_std.dout, last,
                if_std.empty, if_std.full,
                if_std.almost_empty, if_std.almost_full,
                if_std.data_count,
                if_std.overflow, if_std.underflow);
            cmp("ff", if_ff.dout,
                (q.size() > 0) ? q[0] : last,
                if_ff.empty, if_ff.full,
                if_ff.almost_empty, if_ff.almost_full,
                if_ff.data_count,
                if_ff.overflow, if_ff.underflow);
        end
    end

    task automatic step(input logic w,
                        input logic [7:0] d,
                        input logic r);
        @(negedge clk);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_std_cnt"}, 32'(if_std.data_count), 0);
        chk({tag, "_std_empty"}, 32'(if_std.empty), 1);
        chk({tag, "_std_full"}, 32'(if_std.full), 0);
        chk({tag, "_std_ae"}, 32'(if_std.almost_empty), 1);
        chk({tag, "_std_af"}, 32'(if_std.almost_full), 0);
        chk({tag, "_std_dout"}, 32'(if_std.dout), 0);
        chk({tag, "_ff_cnt"}, 32'(if_ff.data_count), 0);
        chk({tag, "_ff_empty"}, 32'(if_ff.empty), 1);
        chk({tag, "_ff_dout"}, 32'(if_ff.dout), 0);
        chk({tag, "_ff_ovf"}, 32'(if_ff.overflow), 0);
        chk({tag, "_ff_unf"}, 32'(if_ff.underflow), 0);
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;
        rd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then one rejected write
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 12)
                chk("t1_af_13", 32'(if_std.almost_full), 0);
            if (i == 13)
                chk("t1_af_14", 32'(if_std.almost_full), 1);
        end
        chk("t1_full", 32'(if_std.full), 1);
        chk("t1_cnt16", 32'(if_std.data_count), 16);
        step(1'b1, 8'h10, 1'b0);
        chk("t1_ovf", 32'(if_std.overflow), 1);
        chk("t1_cnt_hold", 32'(if_std.data_count), 16);
        step(1'b0, 8'h00, 1'b0);
        chk("t1_ovf_clr", 32'(if_std.overflow), 0);

        // Drain in order, then one rejected read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("t2_std_dout", 32'(if_std.dout), 32'(i));
            chk("t2_ff_dout", 32'(if_ff.dout),
                (i < 15) ? 32'(i + 1) : 32'h0f);
            if (i == 12)
                chk("t2_ae_3", 32'(if_std.almost_empty), 0);
            if (i == 13)
                chk("t2_ae_2", 32'(if_std.almost_empty), 1);
        end
        chk("t2_empty", 32'(if_std.empty), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t2_unf", 32'(if_std.underflow), 1);
        chk("t2_dout_hold", 32'(if_std.dout), 32'h0f);
        step(1'b0, 8'h00, 1'b0);

        // Steady count 5 with simultaneous traffic across the wrap
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h25 + i), 1'b1);
            chk("t3_std_dout", 32'(if_std.dout), 32'(8'h20 + i));
            chk("t3_cnt", 32'(if_ff.data_count), 5);
        end
        for (int i = 0; i < 5; i++)
            step(1'b0, 8'h00, 1'b1);
        chk("t3_drained", 32'(if_ff.empty), 1);

        // FWFT fall-through and bypass ordering
        step(1'b1, 8'ha5, 1'b0);
        chk("t4_ff_empty", 32'(if_ff.empty), 0);
        chk("t4_ff_dout", 32'(if_ff.dout), 32'ha5);
        step(1'b1, 8'h5a, 1'b0);
        chk("t4_ff_dout2", 32'(if_ff.dout), 32'ha5);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_ff_rd1", 32'(if_ff.dout), 32'h5a);
        chk("t4_std_rd1", 32'(if_std.dout), 32'ha5);
        step(1'b0, 8'h00, 1'b1);
        chk("t4_ff_empty2", 32'(if_ff.empty), 1);
        chk("t4_ff_hold", 32'(if_ff.dout), 32'h5a);
        step(1'b0, 8'h00, 1'b0);

        // Both requests at full and at empty
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b1, 8'h99, 1'b1);
        chk("t5_ovf", 32'(if_ff.overflow), 1);
        chk("t5_cnt15", 32'(if_ff.data_count), 15);
        chk("t5_std_dout", 32'(if_std.dout), 32'h30);
        chk("t5_ff_dout", 32'(if_ff.dout), 32'h31);
        for (int i = 0; i < 15; i++)
            step(1'b0, 8'h00, 1'b1);
        chk("t5_std_last", 32'(if_std.dout), 32'h3f);
        step(1'b1, 8'h77, 1'b1);
        chk("t5_unf", 32'(if_std.underflow), 1);
        chk("t5_cnt1", 32'(if_std.data_count), 1);
        chk("t5_ff_dout2", 32'(if_ff.dout), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        chk("t5_std_dout2", 32'(if_std.dout), 32'h77);

        // Reset mid-burst at count 9
        for (int i = 0; i < 9; i++)
            step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("t6_cnt9", 32'(if_std.data_count), 9);
        @(negedge clk);
        wr_en = 1'b1;
        din   = 8'h50;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("t6");
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hc3, 1'b0);
        chk("t6_ff_dout", 32'(if_ff.dout), 32'hc3);
        chk("t6_cnt1", 32'(if_std.data_count), 1);
        step(1'b0, 8'h00, 1'b1);
        chk("t6_std_dout", 32'(if_std.dout), 32'hc3);
        chk("t6_empty", 32'(if_std.empty), 1);
        step(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
